// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    // Fetch sequencer states, in the order a normal fetch walks through them.
    typedef enum logic [2:0] {
        S_BOOT,
        S_AR,
        S_R,
        S_ISSUE,
        S_EXEC,
        S_FAULT
    } state_t;

    // AXI read response encoding; anything other than OKAY is an error.
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Reason for a pending fetch fault, as presented to the trap logic.
    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_BUS     = 2'd1,
        FC_TIMEOUT = 2'd2
    } fault_cause_t;

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: one AXI-lite read per instruction, hands the word to
// decode, waits for retirement, then pulses the PC register update enable.
// Bus error responses and response timeouts become a held fetch fault.
module ifu_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    output logic [31:0]      inst,
    output logic             inst_valid,
    input  logic             inst_ready,
    input  logic             wb_done,
    output logic             pc_update,
    output logic             fetch_fault,
    output logic [1:0]       fault_cause,
    output logic [WIDTH-1:0] fault_pc,
    input  logic             fault_ack
);

    // A zero TIMEOUT turns the watchdog off entirely.
    localparam bit               TMO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

    state_t       state;
    state_t       state_nxt;
    fault_cause_t fault_cause_q;
    logic [CNT_W-1:0] tmo_cnt;

    logic tmo_expired;
    logic take_inst;
    logic take_err;
    logic timeout_fault;
    logic fault_clr;

    assign tmo_expired = TMO_EN && (tmo_cnt == TMO_LIMIT);
    assign araddr      = arvalid ? pc : '0;
    assign fault_cause = fault_cause_q;

    // Next-state and output decode; reset forces every handshake output low.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_nxt     = state;
        arvalid       = 1'b0;
        rready        = 1'b0;
        inst_valid    = 1'b0;
        pc_update     = 1'b0;
        fetch_fault   = 1'b0;
        take_inst     = 1'b0;
        take_err      = 1'b0;
        timeout_fault = 1'b0;
        fault_clr     = 1'b0;

        case (state)
            S_BOOT: begin
                state_nxt = S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_nxt = S_R;
                end else if (tmo_expired) begin
                    timeout_fault = 1'b1;
                    state_nxt     = S_FAULT;
                end
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (rresp == RESP_OKAY) begin
                        take_inst = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        take_err  = 1'b1;
                        state_nxt = S_FAULT;
                    end
                end else if (tmo_expired) begin
                    timeout_fault = 1'b1;
                    state_nxt     = S_FAULT;
                end
            end
            S_ISSUE: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (wb_done) begin
                    pc_update = 1'b1;
                    state_nxt = S_AR;
                end
            end
            S_FAULT: begin
                fetch_fault = 1'b1;
                if (fault_ack) begin
                    pc_update = 1'b1;
                    fault_clr = 1'b1;
                    state_nxt = S_AR;
                end
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase

        // Outputs drop in the same cycle reset is seen, not one edge later.
        if (!rst) begin
            state_nxt     = S_BOOT;
            arvalid       = 1'b0;
            rready        = 1'b0;
            inst_valid    = 1'b0;
            pc_update     = 1'b0;
            fetch_fault   = 1'b0;
            take_inst     = 1'b0;
            take_err      = 1'b0;
            timeout_fault = 1'b0;
            fault_clr     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every register in this edge sees
        // the pre-edge values, regardless of the order of the statements.
        if (!rst) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction, fault record and watchdog counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inst          <= '0;
            fault_cause_q <= FC_NONE;
            fault_pc      <= '0;
            tmo_cnt       <= '0;
        end else begin
            // Counter restarts on every entry to S_AR and runs across S_AR+S_R.
            if (state_nxt == S_AR && state != S_AR) begin
                tmo_cnt <= '0;
            end else if (state == S_AR || state == S_R) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (take_inst) begin
                inst <= rdata;
            end

            if (take_err) begin
                fault_cause_q <= FC_BUS;
                fault_pc      <= pc;
            end else if (timeout_fault) begin
                fault_cause_q <= FC_TIMEOUT;
                fault_pc      <= pc;
            end else if (fault_clr) begin
                fault_cause_q <= FC_NONE;
            end
        end
    end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
Fetch sequencer for the multi-cycle core. It takes the current PC from the PC register and issues an AXI-lite-style read on the instruction port. It presents the returned instruction to decode, waits for writeback to finish, then pulses the PC register's update enable. It also detects bus error responses and response timeouts and reports them as fetch faults.

Parameters:
WIDTH, 32, address/data width
TIMEOUT, 255, max cycles spent in S_AR+S_R before a timeout fault; 0 disables the timeout
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
pc  in  WIDTH  current PC from PC register
araddr  out  WIDTH  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rresp  in  2  read response; 2'b00 OKAY, any other value is an error
rvalid  in  1  read data valid
rready  out  1  read data ready
inst  out  32  fetched instruction, registered
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
wb_done  in  1  current instruction has retired
pc_update  out  1  one-cycle enable to the PC register
fetch_fault  out  1  fault pending
fault_cause  out  2  0 none, 1 bus error, 2 timeout
fault_pc  out  WIDTH  PC of the faulting fetch
fault_ack  in  1  trap logic has taken the fault

Behaviour:
- Reset (rst==0 at an edge): state=S_BOOT. inst=0, fault_cause=0, fault_pc=0, timeout counter=0. All valid/ready/update outputs are 0 for as long as reset holds, including a reset asserted mid-transaction. Any outstanding bus beat is abandoned, not waited for.
- S_BOOT: all outputs idle. Next edge goes to S_AR, so the first arvalid appears the 2nd cycle after reset deasserts.
- S_AR: arvalid=1, araddr=pc (combinational; PC is stable here).
  - On arvalid&arready, go to S_R.
  - arvalid and araddr must not change while arready is low.
- S_R: rready=1.
  - On rvalid with rresp==0: capture inst<=rdata and go to S_ISSUE.
  - On rvalid with rresp!=0: capture fault_cause=1 and fault_pc=pc, and go to S_FAULT.
- Timeout:
  - The counter clears on entry to S_AR and increments each cycle in S_AR/S_R.
  - When the counter==TIMEOUT and no handshake completes that cycle: fault_cause=2, fault_pc=pc, go to S_FAULT.
  - A handshake in the same cycle wins over the timeout.
- S_ISSUE: inst_valid=1 and inst is held stable. On inst_ready, go to S_EXEC.
- S_EXEC:
  - When wb_done=1, pc_update=1 in that same cycle (combinational, exactly one cycle), then go to S_AR.
  - The PC register samples the new value at that edge, so araddr in S_AR shows the new PC.
- S_FAULT: fetch_fault=1, fault_cause and fault_pc held.
  - On fault_ack: pc_update=1 for that one cycle (PC loads mtvec via its own select), fault_cause<=0, go to S_AR.
- Ignored inputs:
  - wb_done outside S_EXEC, inst_ready outside S_ISSUE, and fault_ack outside S_FAULT are ignored.
  - rvalid before the AR handshake is ignored (rready=0).
- Exactly one fetch is outstanding at a time; there is no prefetch and no back-to-back AR.
- Minimum loop with zero-wait bus and immediate ready/wb_done: S_AR→S_R→S_ISSUE→S_EXEC, 4 cycles per instruction.

Decomposition:
- Package ifu_pkg holds:
  - state enum {S_BOOT, S_AR, S_R, S_ISSUE, S_EXEC, S_FAULT}
  - RESP_OKAY=2'b00
  - fault cause enum {FC_NONE, FC_BUS, FC_TIMEOUT}
- A single FSM module is sufficient. The timeout counter is inline, with no sub-module.

Test Plan:
- Reset then zero-wait bus, pc=0x80000000, rdata=0x00000013, immediate inst_ready/wb_done → arvalid at cycle 2 after reset release; inst=0x00000013 with inst_valid; pc_update exactly one cycle per 4-cycle loop.
- arready delayed 3 cycles and rvalid delayed 5 cycles → araddr stable throughout, no fault, inst captured on the rvalid cycle.
- rresp=2'b10 at pc=0x80000010 → fetch_fault=1, fault_cause=1, fault_pc=0x80000010. After fault_ack: one pc_update pulse, then a new AR.
- TIMEOUT=4 with arready held at 0 → fault_cause=2 after 5 cycles in S_AR. arready=1 on the counter==4 cycle → handshake taken, no fault.
- Spurious wb_done in S_R and inst_ready in S_EXEC → no pc_update and no state change.
- rst driven low during S_R with rvalid pending → all outputs 0 next edge. Restart from S_BOOT on release; the stale beat is never accepted.
